// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//   Shared definitions for the radix-4 Booth multiplier controller:
//   - state encoding of the control FSM (3-bit)
//   - recode table entries produced by the triplet recoder, packed as
//     {en, resta, sel_m2}
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_OP    = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // en     : write the adder/subtractor result into A
  // resta  : 1 = A - operand, 0 = A + operand
  // sel_m2 : operand is 2M instead of M
  typedef struct packed {
    logic en;
    logic resta;
    logic sel_m2;
  } rec_t;

  localparam rec_t REC_NOP = '{en: 1'b0, resta: 1'b0, sel_m2: 1'b0};
  localparam rec_t REC_PM  = '{en: 1'b1, resta: 1'b0, sel_m2: 1'b0};
  localparam rec_t REC_P2M = '{en: 1'b1, resta: 1'b0, sel_m2: 1'b1};
  localparam rec_t REC_M2M = '{en: 1'b1, resta: 1'b1, sel_m2: 1'b1};
  localparam rec_t REC_MM  = '{en: 1'b1, resta: 1'b1, sel_m2: 1'b0};

endpackage

// File: rtl/booth_r4_recoder.sv
// ---------------------------------------------------------------------------
// booth_r4_recoder
//   Combinational radix-4 Booth recoder: maps the multiplier triplet
//   {q[i+1], q[i], q[i-1]} to the add/subtract action on A.
// Ports
//   trip  in  3  Booth triplet
//   rec   out 3  {en, resta, sel_m2}; resta and sel_m2 are 0 when en is 0
// ---------------------------------------------------------------------------
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] trip,
  output rec_t       rec
);

  always_comb begin
    unique case (trip)
      3'b001, 3'b010: rec = REC_PM;
      3'b011:         rec = REC_P2M;
      3'b100:         rec = REC_M2M;
      3'b101, 3'b110: rec = REC_MM;
      default:        rec = REC_NOP;  // 000 and 111: run of equal bits
    endcase
  end

endmodule

// File: rtl/booth_r4_control.sv
// ---------------------------------------------------------------------------
// booth_r4_control
//   Control unit for a radix-4 Booth signed multiplier. Loads the operands,
//   runs N/2 recode/add + 2-bit shift iterations, then pulses done for one
//   cycle while the product {A, Q[N:1]} is valid. Drives only load, shift and
//   select lines; all arithmetic lives in the datapath.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high
//   start    in   start request, honoured only in IDLE
//   q_trip   in   {Q[2],Q[1],Q[0]} from the Q register (Q[0] = q[-1])
//   busy     out  high in LOAD, OP and SHIFT
//   done     out  one-cycle completion pulse
//   carga_m  out  load M with the sign-extended multiplicand
//   carga_q  out  load Q with {multiplier, 1'b0}
//   clr_a    out  select zero on the A load input
//   carga_a  out  load A from its input
//   desp_a   out  arithmetic right shift of A by 2
//   desp_q   out  right shift of Q by 2, shifting in A[1:0]
//   resta    out  adder mode: 1 = subtract
//   sel_m2   out  operand mux: 1 = 2M, 0 = M
// ---------------------------------------------------------------------------
module booth_r4_control
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] q_trip,
  output logic       busy,
  output logic       done,
  output logic       carga_m,
  output logic       carga_q,
  output logic       clr_a,
  output logic       carga_a,
  output logic       desp_a,
  output logic       desp_q,
  output logic       resta,
  output logic       sel_m2
);

  localparam int ITER = N / 2;
  localparam int CW   = $clog2(ITER) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rec_t          rec;

  booth_r4_recoder u_recoder (
    .trip (q_trip),
    .rec  (rec)
  );

  // State register and iteration counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_d   = CW'(ITER);
        state_d = ST_OP;
      end
      ST_OP:   state_d = ST_SHIFT;  // fixed latency, data independent
      ST_SHIFT: begin
        cnt_d   = cnt_q - CW'(1);
        // Exiting on the last iteration keeps the counter from wrapping.
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_OP;
      end
      ST_DONE: state_d = ST_IDLE;   // start here is dropped, not queued
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore in all states except OP, where the recoded
  // triplet drives the A-load controls. q_trip is ignored elsewhere.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    carga_m = 1'b0;
    carga_q = 1'b0;
    clr_a   = 1'b0;
    carga_a = 1'b0;
    desp_a  = 1'b0;
    desp_q  = 1'b0;
    resta   = 1'b0;
    sel_m2  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        busy    = 1'b1;
        carga_m = 1'b1;
        carga_q = 1'b1;
        carga_a = 1'b1;
        clr_a   = 1'b1;
      end
      ST_OP: begin
        busy    = 1'b1;
        carga_a = rec.en;
        resta   = rec.en & rec.resta;
        sel_m2  = rec.en & rec.sel_m2;
      end
      ST_SHIFT: begin
        busy   = 1'b1;
        desp_a = 1'b1;
        desp_q = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_r4_control.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_control
//   Bench for booth_r4_control with a behavioural A/Q/M datapath (N=4).
//   Stimulus pushes expected products / recode actions into queues; a
//   monitor on the falling edge pops and compares when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_booth_r4_control;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] q_trip;
  logic       busy, done, carga_m, carga_q, clr_a, carga_a, desp_a, desp_q;
  logic       resta, sel_m2;

  always #5 clk = ~clk;

  booth_r4_control #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q_trip  (q_trip),
    .busy    (busy),
    .done    (done),
    .carga_m (carga_m),
    .carga_q (carga_q),
    .clr_a   (clr_a),
    .carga_a (carga_a),
    .desp_a  (desp_a),
    .desp_q  (desp_q),
    .resta   (resta),
    .sel_m2  (sel_m2)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [2*N+1:0] exp_prod_q [$];
  logic [2:0]     exp_rec_q  [$];
  int  done_cnt  = 0;
  int  busy_run  = 0;
  int  cyc       = 0;
  int  last_done = -1;
  bit  use_dp    = 1'b1;   // q_trip from datapath model, else from trip_ptr
  bit  b2b       = 1'b0;   // check done-to-done spacing
  logic [2:0] trip_ptr = 3'd0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {busy, done, carga_m, carga_q, clr_a, carga_a, desp_a, desp_q,
            resta, sel_m2};
  endfunction

  function automatic logic [6:0] trace();
    return {busy, done, carga_m, carga_q, clr_a, desp_a, desp_q};
  endfunction

  // ---------------- datapath model ----------------
  logic signed [N-1:0] mcand = '0, mplier = '0;
  logic [N+1:0] dp_a, dp_m, dp_op;
  logic [N:0]   dp_q;

  assign dp_op = sel_m2 ? {dp_m[N:0], 1'b0} : dp_m;

  always @(posedge clk) begin
    if (carga_m) dp_m <= {{2{mcand[N-1]}}, mcand};
    if (carga_q) dp_q <= {mplier, 1'b0};
    if (carga_a) dp_a <= clr_a ? '0 : (resta ? dp_a - dp_op : dp_a + dp_op);
    else if (desp_a) dp_a <= {{2{dp_a[N+1]}}, dp_a[N+1:2]};
    if (desp_q) dp_q <= {dp_a[1:0], dp_q[N:2]};
    if (!reset && !use_dp && desp_q) trip_ptr <= trip_ptr + 3'd1;
  end

  always_comb q_trip = use_dp ? dp_q[2:0] : trip_ptr;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (!b2b) last_done = -1;
    if (reset) begin
      busy_run = 0;
    end else begin
      check("excl_load_shift", {carga_a & desp_a, carga_q & desp_q}, 0);
      if (!busy && !done) check("idle_quiet", outs(), 0);
      if (busy) busy_run++;
      if (busy && !carga_m && !desp_q && !use_dp) begin
        if (exp_rec_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rec_unexpected: got %b expected none",
                   {carga_a, resta, sel_m2});
        end else begin
          check("recode", {carga_a, resta, sel_m2}, exp_rec_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_len", busy_run, 5);
        check("done_not_busy", busy, 0);
        busy_run = 0;
        if (use_dp) begin
          if (exp_prod_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_unexpected: got done expected none");
          end else begin
            check("product", {dp_a, dp_q[N:1]}, exp_prod_q.pop_front());
          end
        end
        if (b2b && last_done >= 0) check("b2b_gap", cyc - last_done, 7);
        last_done = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within 20");
    end
  endtask

  task automatic do_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                       input logic [2*N+1:0] exp);
    int d0 = done_cnt;
    mcand  = a;
    mplier = b;
    exp_prod_q.push_back(exp);
    pulse_start();
    wait_done(d0);
  endtask

  localparam logic [6:0] SEQ [6] = '{7'b1011100, 7'b1000000, 7'b1000011,
                                     7'b1000000, 7'b1000011, 7'b0100000};
  localparam logic [2:0] REC_EXP [8] = '{3'b000, 3'b100, 3'b100, 3'b101,
                                         3'b111, 3'b110, 3'b110, 3'b000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int k;
    // Reset state
    repeat (2) @(posedge clk);
    #1 check("reset_outs", outs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    // 1: single operation, cycle-by-cycle control sequence, 3 * -2 = -6
    mcand  = 4'sd3;
    mplier = -4'sd2;
    exp_prod_q.push_back(10'h3FA);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("seq%0d", i), trace(), SEQ[i]);
    end
    @(negedge clk);
    check("idle_after", {busy, done}, 0);

    // 3: products through the datapath
    do_op(-4'sd8, -4'sd8, 10'h040);
    do_op( 4'sd7, -4'sd8, 10'h3C8);
    do_op( 4'sd0,  4'sd5, 10'h000);

    // 2: every triplet value in OP, two per operation
    @(posedge clk); #1 use_dp = 1'b0;
    for (int i = 0; i < 8; i++) exp_rec_q.push_back(REC_EXP[i]);
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      pulse_start();
      wait_done(d0);
    end
    @(posedge clk); #1 use_dp = 1'b1;

    // 4: start while busy and during DONE is ignored; -3 * 5 = -15
    d0 = done_cnt;
    mcand  = -4'sd3;
    mplier = 4'sd5;
    exp_prod_q.push_back(10'h3F1);
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    check("one_done_per_start", done_cnt - d0, 1);
    check("no_restart", busy, 0);

    // 5: reset in the second OP cycle
    d0 = done_cnt;
    mcand  = 4'sd2;
    mplier = 4'sd3;
    pulse_start();                 // now in LOAD
    repeat (3) @(posedge clk);     // LOAD->OP->SHIFT->OP
    #2 reset = 1'b1;
    #1 check("reset_async_outs", outs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    do_op(4'sd2, 4'sd3, 10'h006);

    // 6: start held high -> back-to-back ops, done every 7 cycles; -5 * -3 = 15
    @(posedge clk); #1;
    b2b    = 1'b1;
    mcand  = -4'sd5;
    mplier = -4'sd3;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_prod_q.push_back(10'h00F);
    start = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(posedge clk); #1;
      if (done) k++;
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    b2b = 1'b0;
    check("b2b_done_count", done_cnt - d0, 3);
    check("b2b_idle", busy, 0);

    check("prod_queue_empty", exp_prod_q.size(), 0);
    check("rec_queue_empty", exp_rec_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
